// File: rtl/io_periph_ctrl_if.sv
// io_periph_ctrl_if -- CPU MEM-stage load/store bus into the board I/O block.
//   addr   : byte address of the access
//   wr_en  : store qualifier, wdata carries the store data
//   rd_en  : load qualifier, rdata/sel answer in the same cycle
//   rdata  : zero-extended load data (0 when unmapped)
//   sel    : high when addr hits a mapped I/O register
// Modports: master (CPU side) drives the request, slave (peripheral) answers.
interface io_periph_ctrl_if #(
    parameter int DBITS = 32
);
    logic [DBITS-1:0] addr;
    logic             wr_en;
    logic [DBITS-1:0] wdata;
    logic             rd_en;
    logic [DBITS-1:0] rdata;
    logic             sel;

    modport master (output addr, wr_en, wdata, rd_en, input  rdata, sel);
    modport slave  (input  addr, wr_en, wdata, rd_en, output rdata, sel);
endinterface

// File: rtl/io_periph_ctrl.sv
// io_periph_ctrl -- memory-mapped board I/O: seven-segment HEX, LEDR, KEY, SW.
//   clk, reset : core clock, asynchronous active-high reset
//   bus        : io_periph_ctrl_if.slave load/store port (combinational reads)
//   KEY, SW    : raw asynchronous board inputs (KEY active-low)
//   hex_out    : 24-bit seven-segment value, HEXRESET after reset
//   ledr_out   : 10-bit LED value
// Register map: HEX F000, LEDR F020, KDATA F080, KCTRL F084, SDATA F090, SCTRL F094
// (upper address bits FFFFF). CTRL registers: bit0 ready, bit2 overrun.
// Optional feature: define IO_SW_DEBOUNCE_EN to debounce SW over DEBOUNCE_CYCLES
// before it reaches SDATA; otherwise SDATA follows the synchronized SW directly.
module io_periph_ctrl #(
    parameter int          DBITS           = 32,
    parameter int          DEBOUNCE_CYCLES = 500000,
    parameter logic [23:0] HEXRESET        = 24'hFEDEAD
) (
    input  logic                   clk,
    input  logic                   reset,
    io_periph_ctrl_if.slave        bus,
    input  logic [3:0]             KEY,
    input  logic [9:0]             SW,
    output logic [23:0]            hex_out,
    output logic [9:0]             ledr_out
);
    localparam logic [DBITS-1:0] A_HEX   = DBITS'(32'hFFFFF000);
    localparam logic [DBITS-1:0] A_LEDR  = DBITS'(32'hFFFFF020);
    localparam logic [DBITS-1:0] A_KDATA = DBITS'(32'hFFFFF080);
    localparam logic [DBITS-1:0] A_KCTRL = DBITS'(32'hFFFFF084);
    localparam logic [DBITS-1:0] A_SDATA = DBITS'(32'hFFFFF090);
    localparam logic [DBITS-1:0] A_SCTRL = DBITS'(32'hFFFFF094);

    logic [23:0] hex_q, hex_d;
    logic [9:0]  ledr_q, ledr_d;
    // KEY is inverted on entry so the synchronizer's reset value means "not pressed";
    // key_s2_q is KDATA itself.
    logic [3:0]  key_s1_q, key_s2_q, key_prev_q;
    logic [9:0]  sw_s1_q, sw_s2_q;
    logic [9:0]  sdata_q, sdata_d, sdata_prev_q;
    logic        krdy_q, krdy_d, kovr_q, kovr_d;
    logic        srdy_q, srdy_d, sovr_q, sovr_d;

    logic hit_hex, hit_ledr, hit_kdata, hit_kctrl, hit_sdata, hit_sctrl;
    logic kchg, kclr, kwclr, schg, sclr, swclr;
    logic unused_wdata;

    assign hit_hex   = (bus.addr == A_HEX);
    assign hit_ledr  = (bus.addr == A_LEDR);
    assign hit_kdata = (bus.addr == A_KDATA);
    assign hit_kctrl = (bus.addr == A_KCTRL);
    assign hit_sdata = (bus.addr == A_SDATA);
    assign hit_sctrl = (bus.addr == A_SCTRL);
    assign unused_wdata = ^bus.wdata;

    // Change pulses are one cycle after the data register moved, so ready
    // lands the cycle after that.
    assign kchg  = (key_s2_q != key_prev_q);
    assign schg  = (sdata_q != sdata_prev_q);
    assign kclr  = bus.rd_en & hit_kdata;
    assign sclr  = bus.rd_en & hit_sdata;
    assign kwclr = bus.wr_en & hit_kctrl & ~bus.wdata[2];
    assign swclr = bus.wr_en & hit_sctrl & ~bus.wdata[2];

    always_comb begin
        hex_d  = hex_q;
        ledr_d = ledr_q;
        if (bus.wr_en && hit_hex)  hex_d  = bus.wdata[23:0];
        if (bus.wr_en && hit_ledr) ledr_d = bus.wdata[9:0];
        // Set beats a same-cycle clearing read, and that read also masks overrun.
        krdy_d = kchg | (krdy_q & ~kclr);
        kovr_d = (kchg & krdy_q & ~kclr) | (kovr_q & ~kwclr);
        srdy_d = schg | (srdy_q & ~sclr);
        sovr_d = (schg & srdy_q & ~sclr) | (sovr_q & ~swclr);
    end

`ifdef IO_SW_DEBOUNCE_EN
    localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic [9:0]    sw_cand_q;

    // cnt_d is the number of cycles the candidate has been held beyond its
    // first one; any movement of the synchronized value starts over at 0.
    always_comb begin
        cnt_d   = cnt_q;
        sdata_d = sdata_q;
        if (sw_s2_q == sdata_q || sw_s2_q != sw_cand_q) cnt_d = '0;
        else if (cnt_q != CNT_LAST)                     cnt_d = cnt_q + 1'b1;
        if (sw_s2_q != sdata_q && cnt_d == CNT_LAST) sdata_d = sw_s2_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            sw_cand_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            sw_cand_q <= sw_s2_q;
        end
    end
`else
    always_comb sdata_d = sw_s2_q;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hex_q        <= HEXRESET;
            ledr_q       <= '0;
            key_s1_q     <= '0;
            key_s2_q     <= '0;
            key_prev_q   <= '0;
            sw_s1_q      <= '0;
            sw_s2_q      <= '0;
            sdata_q      <= '0;
            sdata_prev_q <= '0;
            krdy_q       <= 1'b0;
            kovr_q       <= 1'b0;
            srdy_q       <= 1'b0;
            sovr_q       <= 1'b0;
        end else begin
            hex_q        <= hex_d;
            ledr_q       <= ledr_d;
            key_s1_q     <= ~KEY;
            key_s2_q     <= key_s1_q;
            key_prev_q   <= key_s2_q;
            sw_s1_q      <= SW;
            sw_s2_q      <= sw_s1_q;
            sdata_q      <= sdata_d;
            sdata_prev_q <= sdata_q;
            krdy_q       <= krdy_d;
            kovr_q       <= kovr_d;
            srdy_q       <= srdy_d;
            sovr_q       <= sovr_d;
        end
    end

    always_comb begin
        bus.rdata = '0;
        if (hit_hex)   bus.rdata = DBITS'(hex_q);
        if (hit_ledr)  bus.rdata = DBITS'(ledr_q);
        if (hit_kdata) bus.rdata = DBITS'(key_s2_q);
        if (hit_kctrl) bus.rdata = DBITS'({kovr_q, 1'b0, krdy_q});
        if (hit_sdata) bus.rdata = DBITS'(sdata_q);
        if (hit_sctrl) bus.rdata = DBITS'({sovr_q, 1'b0, srdy_q});
    end

    assign bus.sel  = hit_hex | hit_ledr | hit_kdata | hit_kctrl | hit_sdata | hit_sctrl;
    assign hex_out  = hex_q;
    assign ledr_out = ledr_q;
endmodule

// File: tb/tb_io_periph_ctrl.sv
// Bench for io_periph_ctrl: expected values are queued as stimulus is driven
// and popped against the DUT's response.
module tb_io_periph_ctrl;
    localparam logic [31:0] A_HEX   = 32'hFFFFF000;
    localparam logic [31:0] A_LEDR  = 32'hFFFFF020;
    localparam logic [31:0] A_KDATA = 32'hFFFFF080;
    localparam logic [31:0] A_KCTRL = 32'hFFFFF084;
    localparam logic [31:0] A_SDATA = 32'hFFFFF090;
    localparam logic [31:0] A_SCTRL = 32'hFFFFF094;
    localparam logic [31:0] A_NONE  = 32'hFFFFF0A0;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  KEY;
    logic [9:0]  SW;
    logic [23:0] hex_out;
    logic [9:0]  ledr_out;

    io_periph_ctrl_if #(.DBITS(32)) bus ();

    io_periph_ctrl #(.DBITS(32), .DEBOUNCE_CYCLES(8), .HEXRESET(24'hFEDEAD)) dut (
        .clk(clk), .reset(reset), .bus(bus), .KEY(KEY), .SW(SW),
        .hex_out(hex_out), .ledr_out(ledr_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic pop_chk(input logic [31:0] got);
        exp_t e;
        if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL sb_empty: got %h, expected nothing queued", got);
        end else begin
            e = sb.pop_front();
            chk(e.tag, got, e.val);
        end
    endtask

    // Load: drives on the falling edge, checks the combinational answer, and
    // holds rd_en through the next rising edge so read-clear side effects occur.
    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input logic exp_sel,
                      input string tag);
        @(negedge clk);
        bus.addr  = a;
        bus.rd_en = 1'b1;
        bus.wr_en = 1'b0;
        push(tag, exp);
        push({tag, "_sel"}, {31'b0, exp_sel});
        #1;
        pop_chk(bus.rdata);
        pop_chk({31'b0, bus.sel});
        @(posedge clk);
        #1;
        bus.rd_en = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.addr  = a;
        bus.wdata = d;
        bus.wr_en = 1'b1;
        bus.rd_en = 1'b0;
        @(posedge clk);
        #1;
        bus.wr_en = 1'b0;
    endtask

    task automatic set_key(input logic [3:0] k, input int wait_edges);
        @(negedge clk);
        KEY = k;
        repeat (wait_edges) @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.addr  = '0;
        bus.wdata = '0;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        KEY   = 4'hF;
        SW    = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        push("rst_hex_out", 32'h00FEDEAD);  pop_chk({8'b0, hex_out});
        push("rst_ledr_out", 32'h0);        pop_chk({22'b0, ledr_out});
        @(negedge clk);
        reset = 1'b0;

        rd(A_HEX,   32'h00FEDEAD, 1'b1, "rd_hex_rst");
        rd(A_LEDR,  32'h0, 1'b1, "rd_ledr_rst");
        rd(A_KDATA, 32'h0, 1'b1, "rd_kdata_rst");
        rd(A_KCTRL, 32'h0, 1'b1, "rd_kctrl_rst");
        rd(A_SCTRL, 32'h0, 1'b1, "rd_sctrl_rst");

        push("hex_out_wr", 32'h00345678);
        wr(A_HEX, 32'h12345678);
        pop_chk({8'b0, hex_out});
        rd(A_HEX, 32'h00345678, 1'b1, "rd_hex_wr");
        push("ledr_out_wr", 32'h3FF);
        wr(A_LEDR, 32'h00000FFF);
        pop_chk({22'b0, ledr_out});
        rd(A_LEDR, 32'h3FF, 1'b1, "rd_ledr_wr");

        // Stores to read-only and unmapped locations are dropped.
        wr(A_KDATA, 32'h5);
        wr(A_NONE, 32'hFFFFFFFF);
        rd(A_KDATA, 32'h0, 1'b1, "rd_kdata_ro");
        push("hex_out_unmapped", 32'h00345678);  pop_chk({8'b0, hex_out});
        rd(A_NONE, 32'h0, 1'b0, "rd_unmapped");

        // Single press: data and ready within 3 cycles, read clears ready.
        set_key(4'hE, 3);
        rd(A_KCTRL, 32'h1, 1'b1, "kctrl_press");
        rd(A_KDATA, 32'h1, 1'b1, "kdata_press");
        rd(A_KCTRL, 32'h0, 1'b1, "kctrl_after_rd");

        // Release, then two changes with no read in between -> overrun.
        set_key(4'hF, 3);
        rd(A_KDATA, 32'h0, 1'b1, "kdata_release");
        set_key(4'hE, 3);
        set_key(4'hC, 3);
        rd(A_KCTRL, 32'h5, 1'b1, "kctrl_overrun");
        wr(A_KCTRL, 32'h4);
        rd(A_KCTRL, 32'h5, 1'b1, "kctrl_wr_bit2_keeps");
        wr(A_KCTRL, 32'h0);
        rd(A_KCTRL, 32'h1, 1'b1, "kctrl_ovr_clr");
        rd(A_KDATA, 32'h3, 1'b1, "kdata_two_keys");
        rd(A_KCTRL, 32'h0, 1'b1, "kctrl_cleared");

        // Clearing read in the same cycle as a change: set wins, no overrun.
        set_key(4'hE, 3);
        set_key(4'hC, 2);
        rd(A_KDATA, 32'h3, 1'b1, "kdata_coincide");
        rd(A_KCTRL, 32'h1, 1'b1, "kctrl_coincide");

        // Load and store together: rdata shows the pre-edge value.
        @(negedge clk);
        bus.addr  = A_HEX;
        bus.wdata = 32'h00ABCDEF;
        bus.wr_en = 1'b1;
        bus.rd_en = 1'b1;
        push("rw_rdata_old", 32'h00345678);
        push("rw_hex_out_new", 32'h00ABCDEF);
        #1;
        pop_chk(bus.rdata);
        @(posedge clk);
        #1;
        pop_chk({8'b0, hex_out});
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;

`ifdef IO_SW_DEBOUNCE_EN
        // Short pulse is rejected; a held value is accepted.
        @(negedge clk);
        SW = 10'h001;
        repeat (5) @(posedge clk);
        @(negedge clk);
        SW = 10'h000;
        repeat (20) @(posedge clk);
        rd(A_SDATA, 32'h0, 1'b1, "sdata_pulse_rej");
        rd(A_SCTRL, 32'h0, 1'b1, "sctrl_pulse_rej");
        @(negedge clk);
        SW = 10'h001;
        repeat (12) @(posedge clk);
        rd(A_SCTRL, 32'h1, 1'b1, "sctrl_held");
        rd(A_SDATA, 32'h1, 1'b1, "sdata_held");
        rd(A_SCTRL, 32'h0, 1'b1, "sctrl_after_rd");
`else
        @(negedge clk);
        SW = 10'h2A5;
        repeat (4) @(posedge clk);
        rd(A_SCTRL, 32'h1, 1'b1, "sctrl_sw");
        rd(A_SDATA, 32'h2A5, 1'b1, "sdata_sw");
        rd(A_SCTRL, 32'h0, 1'b1, "sctrl_after_rd");
`endif

        // Reset mid-activity: pending switch value dropped, KEY still held
        // pressed shows up as a fresh change afterwards.
        @(negedge clk);
        SW = 10'h003;
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        SW    = 10'h000;
        repeat (2) @(posedge clk);
        #1;
        push("rst2_hex_out", 32'h00FEDEAD);  pop_chk({8'b0, hex_out});
        @(negedge clk);
        reset = 1'b0;
        repeat (15) @(posedge clk);
        rd(A_SDATA, 32'h0, 1'b1, "sdata_after_rst");
        rd(A_KCTRL, 32'h1, 1'b1, "kctrl_after_rst");
        rd(A_KDATA, 32'h3, 1'b1, "kdata_after_rst");
        rd(A_LEDR,  32'h0, 1'b1, "ledr_after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
